// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator memory path.
// Used by mem_burst_initiator and its read-return FIFO.
package accel_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int BRAM_BANKS     = 8;
  localparam int MEM_RD_LATENCY = 2;

  typedef struct packed {
    logic                  we;
    logic                  re;
    logic [4:0]            bank_sel;
    logic [15:0]           addr;
    logic [DATA_WIDTH-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } mem_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_FINISH
  } mem_burst_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and flush.
// Read data is the current head (show-ahead).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign data_o  = mem_q[rp_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Storage array; written on accepted push only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= nxt(wp_q);
      if (do_pop)  rp_q <= nxt(rp_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_burst_initiator.sv
// Burst initiator: turns bank/addr/len commands into memory requests.
// Optional read watchdog enabled by defining BURST_INIT_TIMEOUT_EN.
module mem_burst_initiator
  import accel_pkg::*;
#(
  parameter int READ_LATENCY   = MEM_RD_LATENCY,
  parameter int RD_FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [4:0]            cmd_bank,
  input  logic [15:0]           cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output mem_req_t              req,
  input  mem_resp_t             resp,
  input  logic [BRAM_BANKS-1:0] bank_power_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Buffer must cover a full latency window of credits.
  localparam int DEPTH = (RD_FIFO_DEPTH > READ_LATENCY)
                       ? RD_FIFO_DEPTH : READ_LATENCY + 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(BRAM_BANKS);

  mem_burst_state_t state_q;
  logic [BW-1:0]    bank_q;
  logic [15:0]      addr_q;
  logic [8:0]       beats_q;
  logic             abort_q;
  logic             done_q, err_q;
  logic [CW-1:0]    out_q;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_empty;
  logic             cmd_ok, bank_on, credit_ok;
  logic             wr_fire, re_fire, resp_take;
  logic             to_fire;

  assign cmd_ok = (cmd_bank < 5'(BRAM_BANKS))
               && bank_power_en[cmd_bank[BW-1:0]];
  assign bank_on = bank_power_en[bank_q];
  assign credit_ok = ({1'b0, out_q} + {1'b0, fifo_cnt})
                   < (CW+1)'(DEPTH);

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign wr_ready  = (state_q == ST_WRITE) && bank_on;
  assign wr_fire   = wr_ready && wr_valid;
  assign re_fire   = (state_q == ST_READ) && bank_on
                  && credit_ok && !to_fire;
  assign resp_take = resp.valid && (out_q != '0);
  assign rd_valid  = !fifo_empty;
  assign done      = done_q;
  assign err       = err_q;

  // Request bus: live only in the cycle a beat is issued.
  always_comb begin
    req = '0;
    req.we = wr_fire;
    req.re = re_fire;
    if (wr_fire) req.data = wr_data;
    if (wr_fire || re_fire) begin
      req.addr     = addr_q;
      req.bank_sel = 5'(bank_q);
    end
  end

`ifdef BURST_INIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] wd_q;

  // Watchdog: silent cycles while reads are outstanding.
  always_ff @(posedge clk) begin
    if (rst || to_fire || resp.valid || out_q == '0)
      wd_q <= '0;
    else
      wd_q <= wd_q + TW'(1);
  end

  assign to_fire = (out_q != '0) && !resp.valid
                && (wd_q == TW'(TIMEOUT_CYCLES-1));
`else
  // Watchdog compiled out; never fires.
  assign to_fire = (TIMEOUT_CYCLES < 0);
`endif

  // Reads issued to memory and not yet returned.
  always_ff @(posedge clk) begin
    if (rst || to_fire)
      out_q <= '0;
    else
      out_q <= out_q + CW'(re_fire) - CW'(resp_take);
  end

  // Burst control FSM with registered done/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bank_q  <= '0;
      addr_q  <= '0;
      beats_q <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (to_fire) begin
        state_q <= ST_IDLE;
        err_q   <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (cmd_valid && !cmd_ok) begin
              err_q <= 1'b1;
            end else if (cmd_valid) begin
              bank_q  <= cmd_bank[BW-1:0];
              addr_q  <= cmd_addr;
              beats_q <= {1'b0, cmd_len} + 9'd1;
              abort_q <= 1'b0;
              state_q <= cmd_write ? ST_WRITE : ST_READ;
            end
          end
          ST_WRITE: begin
            if (!bank_on) begin
              abort_q <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ST_FINISH;
            end else if (wr_fire) begin
              addr_q  <= addr_q + 16'd1;
              beats_q <= beats_q - 9'd1;
              if (beats_q == 9'd1) begin
                done_q  <= 1'b1;
                state_q <= ST_FINISH;
              end
            end
          end
          ST_READ: begin
            if (!bank_on) begin
              abort_q <= 1'b1;
              state_q <= ST_DRAIN;
            end else if (re_fire) begin
              addr_q  <= addr_q + 16'd1;
              beats_q <= beats_q - 9'd1;
              if (beats_q == 9'd1) state_q <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (out_q == '0 && fifo_empty) begin
              done_q  <= !abort_q;
              err_q   <= abort_q;
              state_q <= ST_FINISH;
            end
          end
          ST_FINISH: state_q <= ST_IDLE;
          default:   state_q <= ST_IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (to_fire),
    .push_i  (resp_take),
    .data_i  (resp.data),
    .pop_i   (rd_valid && rd_ready),
    .data_o  (rd_data),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Scoreboard bench for mem_burst_initiator with a memory model.
// Expected traffic comes from a bank/address map of written data.
module tb_mem_burst_initiator;
  import accel_pkg::*;

  localparam int RL  = 2;
  localparam int DEP = 4;
  localparam int TO  = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cmd_valid, cmd_ready, cmd_write;
  logic [4:0]            cmd_bank;
  logic [15:0]           cmd_addr;
  logic [7:0]            cmd_len;
  logic                  wr_valid, wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid, rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  mem_req_t              req;
  mem_resp_t             resp;
  logic [BRAM_BANKS-1:0] pwr;
  logic                  busy, done, err;

  always #5 clk = ~clk;

  mem_burst_initiator #(
    .READ_LATENCY   (RL),
    .RD_FIFO_DEPTH  (DEP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_write (cmd_write), .cmd_bank (cmd_bank),
    .cmd_addr (cmd_addr), .cmd_len (cmd_len),
    .wr_valid (wr_valid), .wr_ready (wr_ready),
    .wr_data (wr_data),
    .rd_valid (rd_valid), .rd_ready (rd_ready),
    .rd_data (rd_data),
    .req (req), .resp (resp),
    .bank_power_en (pwr),
    .busy (busy), .done (done), .err (err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  bank;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } pend_t;

  wr_exp_t     exp_wr[$];
  logic [15:0] exp_ra[$];
  logic [31:0] exp_rd[$];
  bit          exp_ev[$];
  pend_t       pend[$];
  logic [31:0] ref_mem[bit [20:0]];
  logic [31:0] env_mem[bit [20:0]];

  bit env_mute = 1'b0;
  int rd_hold  = 0;
  bit rd_rand  = 1'b0;
  int first_re = -1;
  int first_rv = -1;
  int re_cnt   = 0;

  // Memory controller model: fixed read latency.
  always @(negedge clk) begin
    bit [20:0] k;
    k = {req.bank_sel, req.addr};
    if (req.we) env_mem[k] = req.data;
    if (req.re && !env_mute)
      pend.push_back('{cyc + RL,
        env_mem.exists(k) ? env_mem[k] : 32'h0});
  end

  always @(posedge clk) begin
    pend_t p;
    #1;
    resp = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      resp.valid = 1'b1;
      resp.data  = p.d;
    end
  end

  // Read-side consumer.
  always @(posedge clk) begin
    #1;
    if (rd_hold > 0) begin
      rd_ready = 1'b0;
      rd_hold--;
    end else begin
      rd_ready = rd_rand ? ($urandom % 3 != 0) : 1'b1;
    end
  end

  // Monitor: pops and compares whatever the DUT presents.
  always @(negedge clk) begin
    wr_exp_t e;
    if (!rst) begin
      if (req.we && req.re) chk("we_re_excl", 1'b1, 1'b0);
      if (req.we) begin
        if (exp_wr.size() == 0) begin
          chk("unexp_we", exp_wr.size(), 1);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_bank", req.bank_sel, e.bank);
          chk("wr_addr", req.addr, e.addr);
          chk("wr_data", req.data, e.data);
        end
      end
      if (req.re) begin
        re_cnt++;
        if (first_re < 0) first_re = cyc;
        if (exp_ra.size() == 0)
          chk("unexp_re", exp_ra.size(), 1);
        else
          chk("re_addr", req.addr, exp_ra.pop_front());
      end
      if (rd_valid && first_rv < 0) first_rv = cyc;
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0)
          chk("unexp_rd", exp_rd.size(), 1);
        else
          chk("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done || err) begin
        chk("done_err_excl", done && err, 1'b0);
        if (exp_ev.size() == 0)
          chk("unexp_evt", exp_ev.size(), 1);
        else
          chk("evt_is_err", err, exp_ev.pop_front());
      end
    end
  end

  function automatic bit bank_ok(input int b);
    return (b < BRAM_BANKS) && pwr[b];
  endfunction

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_wait"}, n >= 2000, 1'b0);
  endtask

  task automatic issue(input bit w, input int b,
                       input int a, input int l);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_bank  = 5'(b);
    cmd_addr  = 16'(a);
    cmd_len   = 8'(l);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input int b, input int a,
                          input int l, input bit fixed,
                          input int cut);
    logic [31:0] d[$];
    int n = l + 1;
    int i = 0;
    int g = 0;
    if (!bank_ok(b)) begin
      exp_ev.push_back(1'b1);
      issue(1'b1, b, a, l);
      wait_idle("wr_bad");
      return;
    end
    for (int j = 0; j < n; j++) begin
      logic [15:0] ad;
      d.push_back(fixed ? 32'hAA + 32'(j) * 32'h11
                        : $urandom);
      ad = 16'(a + j);
      if (j < cut) begin
        exp_wr.push_back('{5'(b), ad, d[j]});
        ref_mem[{5'(b), ad}] = d[j];
      end
    end
    exp_ev.push_back(cut < n);
    issue(1'b1, b, a, l);
    while (i < n && i < cut && g < 1000) begin
      wr_valid = ($urandom % 4 != 0);
      wr_data  = d[i];
      @(negedge clk);
      if (wr_valid && wr_ready) i++;
      @(posedge clk); #1;
      g++;
    end
    wr_valid = 1'b0;
    if (cut < n) begin
      pwr[b] = 1'b0;
      @(negedge clk);
      chk("pd_wr_ready", wr_ready, 1'b0);
      @(negedge clk);
      chk("pd_err", err, 1'b1);
      pwr[b] = 1'b1;
    end else begin
      @(negedge clk);
      chk("wr_done_timing", done, 1'b1);
    end
    wait_idle("wr");
  endtask

  task automatic push_read(input int b, input int a,
                           input int l);
    for (int j = 0; j <= l; j++) begin
      bit [20:0] k;
      k = {5'(b), 16'(a + j)};
      exp_ra.push_back(16'(a + j));
      exp_rd.push_back(ref_mem.exists(k) ? ref_mem[k]
                                         : 32'h0);
    end
  endtask

  task automatic do_read(input int b, input int a,
                         input int l);
    if (!bank_ok(b)) begin
      exp_ev.push_back(1'b1);
      issue(1'b0, b, a, l);
      wait_idle("rd_bad");
      return;
    end
    push_read(b, a, l);
    exp_ev.push_back(1'b0);
    first_re = -1;
    first_rv = -1;
    re_cnt   = 0;
    issue(1'b0, b, a, l);
    wait_idle("rd");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_bank = '0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    rd_ready = 1'b1;
    resp = '0;
    pwr = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_req", req, '0);
    chk("rst_done_err", {done, err}, 2'b00);

    do_write(0, 16'h0010, 3, 1'b1, 999);
    do_read(0, 16'h0010, 3);
    chk("rd_latency", first_rv - first_re, RL + 1);

    for (int j = 0; j < 16; j++)
      ref_mem[{5'd3, 16'(16'h0100 + j)}] = 32'h0;
    do_write(3, 16'h0100, 15, 1'b0, 999);
    push_read(3, 16'h0100, 15);
    exp_ev.push_back(1'b0);
    re_cnt = 0;
    rd_hold = 22;
    issue(1'b0, 3, 16'h0100, 15);
    repeat (20) @(negedge clk);
    chk("credit_re_cnt", re_cnt, DEP);
    chk("credit_rd_valid", rd_valid, 1'b1);
    wait_idle("rd16");

    pwr[4] = 1'b0;
    exp_ev.push_back(1'b1);
    issue(1'b1, 4, 16'h0000, 2);
    @(negedge clk);
    chk("bad_bank_err", err, 1'b1);
    chk("bad_bank_ready", cmd_ready, 1'b1);
    pwr[4] = 1'b1;
    exp_ev.push_back(1'b1);
    issue(1'b0, 9, 16'h0000, 0);
    @(negedge clk);
    chk("oob_bank_err", err, 1'b1);

    do_write(1, 16'hFFFE, 3, 1'b0, 999);
    do_read(1, 16'hFFFE, 3);

    do_write(2, 16'h0200, 7, 1'b0, 3);
    do_read(2, 16'h0200, 3);

    rd_rand = 1'b1;
    for (int t = 0; t < 14; t++) begin
      int b = $urandom % 10;
      int a = $urandom % 65536;
      int l = $urandom % 12;
      if ($urandom % 2 == 1)
        do_write(b, a, l, 1'b0, 999);
      else
        do_read(b % 4, 16'hFFF8 + ($urandom % 8), l);
    end
    rd_rand = 1'b0;

`ifdef BURST_INIT_TIMEOUT_EN
    env_mute = 1'b1;
    for (int j = 0; j < 4; j++)
      exp_ra.push_back(16'(16'h0040 + j));
    exp_ev.push_back(1'b1);
    issue(1'b0, 0, 16'h0040, 3);
    wait_idle("timeout");
    chk("to_rd_valid", rd_valid, 1'b0);
    env_mute = 1'b0;
`endif

    push_read(1, 16'h0300, 7);
    exp_ev.push_back(1'b0);
    rd_hold = 40;
    issue(1'b0, 1, 16'h0300, 7);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    exp_ra.delete();
    exp_rd.delete();
    exp_ev.delete();
    @(posedge clk); #1 rst = 1'b0;
    rd_hold = 0;
    @(negedge clk);
    chk("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rd_valid", rd_valid, 1'b0);
    chk("mid_rst_req", req, '0);
    chk("mid_rst_wr_ready", wr_ready, 1'b0);
    chk("mid_rst_done_err", {done, err}, 2'b00);
    begin
      bit seen = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (rd_valid) seen = 1'b1;
      end
      chk("post_rst_ignored", seen, 1'b0);
    end

    do_write(5, 16'h0020, 1, 1'b0, 999);
    do_read(5, 16'h0020, 1);

    chk("sb_wr_left", exp_wr.size(), 0);
    chk("sb_ra_left", exp_ra.size(), 0);
    chk("sb_rd_left", exp_rd.size(), 0);
    chk("sb_ev_left", exp_ev.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_burst_initiator.md
MEM_BURST_INITIATOR -- requirements
Module: mem_burst_initiator

Interface
REQ-001 Parameter READ_LATENCY, default 2: cycles from a sampled req.re to the matching resp.valid.
REQ-002 Parameter RD_FIFO_DEPTH, default 4: read-return buffer entries; SHALL be at least READ_LATENCY+1.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: read watchdog limit; used only under REQ-027.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid in 1, cmd_ready out 1: command handshake; transfer when both are high.
REQ-007 cmd_write in 1 (1 = write burst, 0 = read burst); cmd_bank in 5; cmd_addr in 16; cmd_len in 8, beats minus one (1..256 beats).
REQ-008 wr_valid in 1, wr_ready out 1, wr_data in DATA_WIDTH: write-data stream.
REQ-009 rd_valid out 1, rd_ready in 1, rd_data out DATA_WIDTH: read-data stream.
REQ-010 req out mem_req_t: request to memory_controller; resp in mem_resp_t: response from memory_controller.
REQ-011 bank_power_en in BRAM_BANKS: per-bank power state, same vector the controller receives.
REQ-012 busy out 1: burst in progress; done out 1: one-cycle completion pulse; err out 1: one-cycle error pulse.

Function
REQ-013 States: IDLE, WRITE, READ, DRAIN, FINISH.
REQ-014 cmd_ready is high only in IDLE; busy is high in every state except IDLE.
REQ-015 Command accepted with bank_power_en[cmd_bank]=0, or cmd_bank >= BRAM_BANKS: err pulses the next cycle, no req is issued, FSM stays IDLE.
REQ-016 All other accepted commands: latch bank, addr and beat count; go to WRITE or READ per cmd_write.
REQ-017 WRITE: wr_ready=1; each wr_valid&wr_ready cycle drives req.we=1, req.data=wr_data, req.addr=current addr, req.bank_sel=latched bank for exactly that cycle.
REQ-018 WRITE: idle cycles drive req.we=0; the last beat moves to FINISH.
REQ-019 READ: drive req.re=1 for one cycle per beat only when outstanding+fifo_count < RD_FIFO_DEPTH (credit rule); otherwise drive req.re=0.
REQ-020 READ: after the last re, go to DRAIN.
REQ-021 Each resp.valid pushes resp.data into the read FIFO, even when rd_ready is held low (FIFO never overflows).
REQ-022 DRAIN: leave for FINISH when outstanding=0 and the FIFO is empty.
REQ-023 FINISH: pulse done for 1 cycle, then return to IDLE.
REQ-024 Address increments by 1 per beat and wraps 0xFFFF->0x0000; req.we and req.re are never high together.
REQ-025 rd_data/rd_valid present the FIFO head; first-word latency = READ_LATENCY+1 cycles from the first req.re.
REQ-026 Bank powered down mid-burst: stop issuing requests, discard remaining write beats (wr_ready=0), let outstanding reads land, pulse err in FINISH instead of done.

Configuration
REQ-027 With BURST_INIT_TIMEOUT_EN defined: if outstanding>0 and no resp.valid arrives for TIMEOUT_CYCLES cycles, clear outstanding, flush the FIFO, pulse err, return to IDLE.
REQ-028 Without BURST_INIT_TIMEOUT_EN: no counter exists; DRAIN waits indefinitely.

Reset
REQ-029 rst (sampled) forces: state IDLE; cmd_ready=1; wr_ready=0; rd_valid=0; req all zero; busy=0; done=0; err=0; FIFO empty; outstanding=0.
REQ-030 Reset mid-burst abandons the burst; responses arriving after reset are ignored (outstanding=0 blocks the push).

Structure
REQ-031 accel_pkg: DATA_WIDTH, BRAM_BANKS, mem_req_t, mem_resp_t, plus new mem_burst_state_t enum and MEM_RD_LATENCY constant.
REQ-032 One sub-module: sync_fifo (parameterised width/depth, count output) for the read return path.

Verification
REQ-033 Write bank 0, addr 0x0010, len 3, data AA,BB,CC,DD -> four req.we pulses at addr 0x10..0x13, done 1 cycle after the last beat.
REQ-034 Read the same burst with rd_ready=1 -> rd_data AA,BB,CC,DD; first rd_valid exactly READ_LATENCY+1 cycles after the first req.re.
REQ-035 16-beat read with rd_ready=0 for 20 cycles -> at most RD_FIFO_DEPTH re issued, no data lost, then all 16 in order once rd_ready=1.
REQ-036 Command to bank 4 with bank_power_en[4]=0 -> err pulse, zero req.we/re cycles, cmd_ready back high.
REQ-037 Write at addr 0xFFFE, len 3 -> addresses FFFE, FFFF, 0000, 0001.
REQ-038 With BURST_INIT_TIMEOUT_EN, resp.valid held 0 -> err 16 cycles after the last response, then IDLE; rst asserted mid-burst -> all outputs at reset values the next cycle.
